// File: rtl/priority_encoder_8to3.sv
// Priority encoder over a registered pending set: issues one 3-bit index per cycle
// with valid/ready handshake. Define PRIO_ROTATE_EN for round-robin instead of fixed priority.
module priority_encoder_8to3 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       load,
  input  logic [7:0] req_in,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [2:0] out_idx,
  output logic [7:0] pend,
  output logic [3:0] pend_cnt,
  output logic       busy
);

  typedef enum logic {IDLE, PRESENT} state_t;

  state_t     state, state_nxt;
  logic [7:0] pend_nxt;
  logic [7:0] grant_mask;
  logic [2:0] gidx;
  logic [2:0] idx_nxt;
  logic       found;
  logic       issue;

`ifdef PRIO_ROTATE_EN
  logic [2:0] ptr, ptr_nxt;

  // Search starts at ptr and wraps 7->0.
  always_comb begin
    found = 1'b0;
    gidx  = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (!found && pend[ptr + 3'(i)]) begin
        found = 1'b1;
        gidx  = ptr + 3'(i);
      end
    end
  end

  always_comb begin
    ptr_nxt = ptr;
    if (issue) ptr_nxt = gidx + 3'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr <= 3'd0;
    else        ptr <= ptr_nxt;
  end
`else
  always_comb begin
    found = 1'b0;
    gidx  = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (!found && pend[i]) begin
        found = 1'b1;
        gidx  = 3'(i);
      end
    end
  end
`endif

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    case (state)
      IDLE: begin
        if (en && found) begin
          issue     = 1'b1;
          state_nxt = PRESENT;
        end
      end
      PRESENT: begin
        // Held output completes its transfer even with en low.
        if (out_ready) begin
          if (en && found) issue = 1'b1;
          else             state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    grant_mask = issue ? (8'b1 << gidx) : 8'h00;
    // A new request on the bit granted this edge stays pending.
    pend_nxt   = (pend & ~grant_mask) | ((en && load) ? req_in : 8'h00);
    idx_nxt    = issue ? gidx : out_idx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      pend    <= 8'h00;
      out_idx <= 3'd0;
    end else begin
      state   <= state_nxt;
      pend    <= pend_nxt;
      out_idx <= idx_nxt;
    end
  end

  always_comb begin
    pend_cnt = 4'd0;
    for (int i = 0; i < 8; i++) pend_cnt = pend_cnt + 4'(pend[i]);
  end

  assign out_valid = (state == PRESENT);
  assign busy      = out_valid | (pend != 8'h00);

endmodule

// File: tb/tb_priority_encoder_8to3.sv
// Directed bench for priority_encoder_8to3; issued indices checked against a scoreboard queue.
module tb_priority_encoder_8to3;

  logic       clk, rst_n, en, load, out_ready;
  logic [7:0] req_in;
  logic       out_valid, busy;
  logic [2:0] out_idx;
  logic [7:0] pend;
  logic [3:0] pend_cnt;

  int checks   = 0;
  int failures = 0;
  logic [2:0] exp_q[$];

  priority_encoder_8to3 dut (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load), .req_in(req_in),
    .out_ready(out_ready), .out_valid(out_valid), .out_idx(out_idx),
    .pend(pend), .pend_cnt(pend_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        failures++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  // One clock; a transfer happening at this edge is checked against the scoreboard.
  task automatic step();
    logic [2:0] e;
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $error("FAIL sb_unexpected observed=%0h expected=none", out_idx);
      end else begin
        e = exp_q.pop_front();
        chk("sb_idx", {5'b0, out_idx}, {5'b0, e});
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((out_valid || pend != 8'h00) && n < budget) begin
      step();
      n++;
    end
    chk("drain_done", {7'b0, (out_valid || pend != 8'h00)}, 8'h00);
    chk("sb_empty", 8'(exp_q.size()), 8'h00);
  endtask

  initial begin
    clk = 0; rst_n = 0; en = 0; load = 0; req_in = 8'h00; out_ready = 0;
    #12;
    chk("rst_valid", {7'b0, out_valid}, 8'h00);
    chk("rst_pend", pend, 8'h00);
    chk("rst_idx", {5'b0, out_idx}, 8'h00);
    chk("rst_cnt", {4'b0, pend_cnt}, 8'h00);
    chk("rst_busy", {7'b0, busy}, 8'h00);
    rst_n = 1;
    step();

    // Fixed drain of 1010_0101
    en = 1; out_ready = 1; load = 1; req_in = 8'hA5;
    exp_q.push_back(3'd0); exp_q.push_back(3'd2);
    exp_q.push_back(3'd5); exp_q.push_back(3'd7);
    step();
    load = 0; req_in = 8'h00;
    chk("drain_pend", pend, 8'hA5);
    chk("drain_cnt0", {4'b0, pend_cnt}, 8'd4);
    chk("drain_latency", {7'b0, out_valid}, 8'h00);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("drain_valid", {7'b0, out_valid}, 8'h01);
      chk("drain_cnt", {4'b0, pend_cnt}, 8'(3 - i));
    end
    step();
    chk("drain_idle", {7'b0, out_valid}, 8'h00);
    chk("idx_retained", {5'b0, out_idx}, 8'd7);
    chk("drain_sb_empty", 8'(exp_q.size()), 8'h00);

    // Backpressure
    out_ready = 0; load = 1; req_in = 8'h81;
    exp_q.push_back(3'd0); exp_q.push_back(3'd7);
    step();
    load = 0; req_in = 8'h00;
    step();
    for (int i = 0; i < 5; i++) begin
      chk("bp_idx", {5'b0, out_idx}, 8'd0);
      chk("bp_valid", {7'b0, out_valid}, 8'h01);
      chk("bp_pend", pend, 8'h80);
      chk("bp_busy", {7'b0, busy}, 8'h01);
      step();
    end
    out_ready = 1;
    step();
    chk("bp_next_idx", {5'b0, out_idx}, 8'd7);
    step();
    chk("bp_idle", {7'b0, out_valid}, 8'h00);

    // Load of the bit being granted at the same edge
    load = 1; req_in = 8'h08;
    exp_q.push_back(3'd3); exp_q.push_back(3'd3);
    step();
    step();
    load = 0; req_in = 8'h00;
    chk("sim_pend", pend, 8'h08);
    chk("sim_idx", {5'b0, out_idx}, 8'd3);
    step();
    chk("sim_pend_clr", pend, 8'h00);
    chk("sim_valid", {7'b0, out_valid}, 8'h01);
    step();
    chk("sim_idle", {7'b0, out_valid}, 8'h00);

    // Merge of an already pending bit
    out_ready = 0; load = 1; req_in = 8'h05;
    step();
    req_in = 8'h04;
    step();
    load = 0; req_in = 8'h00;
    chk("merge_pend", pend, 8'h04);
    chk("merge_cnt", {4'b0, pend_cnt}, 8'd1);
    exp_q.push_back(3'd0); exp_q.push_back(3'd2);
    out_ready = 1;
    drain(20);

    // Enable gating
    load = 1; req_in = 8'h03;
    step();
    en = 0; req_in = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("en_pend", pend, 8'h03);
      chk("en_valid", {7'b0, out_valid}, 8'h00);
    end
    load = 0; req_in = 8'h00; en = 1;
    exp_q.push_back(3'd0); exp_q.push_back(3'd1);
    step();
    chk("en_resume", {7'b0, out_valid}, 8'h01);
    en = 0;
    step();
    chk("en_xfer_done", {7'b0, out_valid}, 8'h00);
    chk("en_pend_left", pend, 8'h02);
    en = 1;
    step();
    chk("en_reissue", {7'b0, out_valid}, 8'h01);
    step();
    chk("en_idle", {7'b0, out_valid}, 8'h00);

    // Asynchronous reset while presenting
    out_ready = 0; load = 1; req_in = 8'hF8;
    step();
    load = 0; req_in = 8'h00;
    step();
    chk("pre_rst_pend", pend, 8'hF0);
    chk("pre_rst_valid", {7'b0, out_valid}, 8'h01);
    #2 rst_n = 0;
    #1;
    exp_q.delete();
    chk("arst_valid", {7'b0, out_valid}, 8'h00);
    chk("arst_pend", pend, 8'h00);
    chk("arst_idx", {5'b0, out_idx}, 8'h00);
    chk("arst_busy", {7'b0, busy}, 8'h00);
    out_ready = 1; en = 1;
    #3 rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("post_rst_valid", {7'b0, out_valid}, 8'h00);
      chk("post_rst_pend", pend, 8'h00);
    end

    // Priority order: rotate gives 0,3,0; fixed gives 0,0,3
    out_ready = 0; load = 1; req_in = 8'h09;
    step();
    load = 0; req_in = 8'h00;
    step();
    load = 1; req_in = 8'h01;
    step();
    load = 0; req_in = 8'h00;
    chk("order_pend", pend, 8'h09);
    chk("order_first", {5'b0, out_idx}, 8'd0);
    exp_q.push_back(3'd0);
`ifdef PRIO_ROTATE_EN
    exp_q.push_back(3'd3); exp_q.push_back(3'd0);
`else
    exp_q.push_back(3'd0); exp_q.push_back(3'd3);
`endif
    out_ready = 1;
    drain(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
